// File: rtl/prime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prime_gen
//  Description : Enumerates every prime 2..limit in ascending order on a
//                valid/ready stream, using trial division by repeated
//                subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  limit,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  p,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRY  = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [W-1:0]  C_TWO     = W'(2);
    localparam logic [W-1:0]  C_FOUR    = W'(4);
    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  lim_q,   lim_d;
    logic [W-1:0]  n_q,     n_d;
    logic [W-1:0]  d_q,     d_d;
    logic [W-1:0]  r_q,     r_d;
    logic [W-1:0]  p_q,     p_d;
    logic [CW-1:0] count_q, count_d;

    // Next divisor and its square, at full width so the d*d > n test never overflows.
    logic [W:0]     w_dinc;
    logic [2*W+1:0] w_dinc_sq;
    logic [2*W+1:0] w_n_ext;

    assign w_dinc    = {1'b0, d_q} + {{W{1'b0}}, 1'b1};
    assign w_dinc_sq = {{(W+1){1'b0}}, w_dinc} * {{(W+1){1'b0}}, w_dinc};
    assign w_n_ext   = {{(W+2){1'b0}}, n_q};

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        n_d     = n_q;
        d_d     = d_q;
        r_d     = r_q;
        p_d     = p_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lim_d   = limit;
                    n_d     = C_TWO;
                    d_d     = '0;
                    r_d     = '0;
                    count_d = '0;
                    state_d = (limit < C_TWO) ? S_FIN : S_TRY;
                end
            end
            S_TRY: begin
                d_d = C_TWO;
                if (n_q < C_FOUR) begin
                    p_d     = n_q;
                    state_d = S_EMIT;
                end else begin
                    r_d     = n_q;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (r_q >= d_q) begin
                    r_d = r_q - d_q;
                end else if (r_q == '0) begin
                    state_d = S_NEXT;
                end else if (w_dinc_sq > w_n_ext) begin
                    p_d     = n_q;
                    state_d = S_EMIT;
                end else begin
                    // d+1 squared fits below n, so d+1 itself fits in W bits.
                    d_d = w_dinc[W-1:0];
                    r_d = n_q;
                end
            end
            S_EMIT: begin
                if (ready) begin
                    count_d = (count_q == C_CNT_MAX) ? count_q : count_q + 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Compare before incrementing so n never wraps at lim = 2^W-1.
                if (n_q == lim_q) begin
                    state_d = S_FIN;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_TRY;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            n_q     <= n_d;
            d_q     <= d_d;
            r_q     <= r_d;
            p_q     <= p_d;
            count_q <= count_d;
        end
    end

    assign valid = (state_q == S_EMIT);
    assign busy  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done  = (state_q == S_FIN);
    assign p     = p_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_gen
//  Description : Scoreboard bench for prime_gen; expected primes come from an
//                independent modulo-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_gen;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  limit;
    logic          ready;
    logic          valid;
    logic [W-1:0]  p;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_q[$];

    prime_gen #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .limit (limit),
        .ready (ready),
        .valid (valid),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int k = 2; k * k <= v; k++)
            if (v % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_expected(input int lim);
        for (int v = 2; v <= lim; v++)
            if (is_prime(v)) exp_q.push_back(v[W-1:0]);
    endtask

    task automatic pulse_start(input int lim);
        @(negedge clk);
        start = 1'b1;
        limit = lim[W-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the stream until done, popping the scoreboard on every transfer.
    // mode 0: ready always high, mode 1: ready high one cycle in three.
    task automatic drain(input int mode, input int budget, input int exp_count,
                         output int first_v, output int done_at);
        bit           prev_stall;
        logic [W-1:0] prev_p;
        logic [W-1:0] e;
        bit           got_done;
        prev_stall = 1'b0;
        prev_p     = '0;
        got_done   = 1'b0;
        first_v    = -1;
        done_at    = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (prev_stall) begin
                total_cnt++;
                if (valid !== 1'b1 || p !== prev_p)
                    $display("FAIL stall_hold: valid=%0b p=%0d required valid=1 p=%0d", valid, p, prev_p);
                else
                    pass_cnt++;
            end
            if (valid === 1'b1 && first_v < 0) first_v = cyc;
            if (valid === 1'b1 && ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_prime: got p=%0d required none", p);
                end else begin
                    e = exp_q.pop_front();
                    if (p !== e)
                        $display("FAIL prime_value: got %0d required %0d", p, e);
                    else
                        pass_cnt++;
                end
            end
            prev_stall = (valid === 1'b1) && !ready;
            prev_p     = p;
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_at  = cyc;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!got_done) $display("FAIL done_timeout: got no done required done within %0d cycles", budget);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL missing_primes: got %0d left required 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (count !== exp_count[CW-1:0] || busy !== 1'b0)
            $display("FAIL end_state: count=%0d busy=%0b required count=%0d busy=0", count, busy, exp_count);
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({valid, p, busy, done, count} !== '0)
            $display("FAIL reset_state: valid=%0b p=%0d busy=%0b done=%0b count=%0d required all 0",
                     valid, p, busy, done, count);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lim15();
        int fv, da;
        push_expected(15);
        pulse_start(15);
        drain(0, 2000, 6, fv, da);
        total_cnt++;
        if (fv < 0 || fv > 2) $display("FAIL first_latency: got %0d cycles required <=2", fv);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd6)
            $display("FAIL after_done: done=%0b busy=%0b count=%0d required 0 0 6", done, busy, count);
        else pass_cnt++;
    endtask

    task automatic test_small_limits();
        int fv, da;
        for (int i = 0; i < 2; i++) begin
            pulse_start(1 - i);
            drain(0, 20, 0, fv, da);
            total_cnt++;
            if (fv != -1 || da < 0 || da > 2)
                $display("FAIL small_limit: lim=%0d first_valid=%0d done_at=%0d required -1 and <=2", 1 - i, fv, da);
            else pass_cnt++;
        end
    endtask

    task automatic test_lim2_lim4();
        int fv, da;
        push_expected(2);
        pulse_start(2);
        drain(0, 200, 1, fv, da);
        push_expected(4);
        pulse_start(4);
        drain(0, 200, 2, fv, da);
    endtask

    task automatic test_stall();
        int fv, da;
        push_expected(15);
        pulse_start(15);
        drain(1, 3000, 6, fv, da);
    endtask

    task automatic test_lim255();
        int fv, da;
        push_expected(255);
        pulse_start(255);
        drain(0, 80000, 54, fv, da);
    endtask

    task automatic test_back_to_back();
        int fv, da;
        push_expected(2);
        pulse_start(2);
        drain(0, 200, 1, fv, da);
        // Start during the done cycle must be ignored; the next cycle's start is taken.
        start = 1'b1;
        limit = 8'd7;
        @(negedge clk);
        limit = 8'd4;
        @(negedge clk);
        start = 1'b0;
        push_expected(4);
        drain(0, 200, 2, fv, da);
    endtask

    task automatic test_reset_mid();
        int  fv, da;
        bit  found;
        found = 1'b0;
        pulse_start(15);
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (valid === 1'b1 && p === 8'd7) begin
                found = 1'b1;
                ready = 1'b0;
                break;
            end
            ready = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (!found) $display("FAIL reach_p7: got no valid p=7 required one");
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'b0)
            $display("FAIL mid_reset: valid=%0b busy=%0b count=%0d done=%0b required all 0", valid, busy, count, done);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (done !== 1'b0 || valid !== 1'b0)
                $display("FAIL post_reset_quiet: done=%0b valid=%0b required 0 0", done, valid);
            else pass_cnt++;
        end
        push_expected(4);
        pulse_start(4);
        start = 1'b1;
        limit = 8'd2;
        @(negedge clk);
        start = 1'b0;
        drain(0, 200, 2, fv, da);
        push_expected(15);
        pulse_start(15);
        drain(0, 2000, 6, fv, da);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        limit = '0;
        ready = 1'b0;
        test_reset();
        test_lim15();
        test_small_limits();
        test_lim2_lim4();
        test_stall();
        test_lim255();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
